morse_display_buffer: RTL
=========================

MORSE_DISPLAY_BUFFER -- requirements
Module: morse_display_buffer

Interface
REQ-001 Parameter NUM_DIGITS, default 8, number of seven-segment digits held (legal 2..16).
REQ-002 Parameter SCAN_DIV, default 100000, clock cycles each digit is driven during display scan (legal >= 2).
REQ-003 Localparam IDX_W = $clog2(NUM_DIGITS), the width of the digit index.
REQ-004 clk_100Mhz  input  1  single system clock; all logic is on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 data_valid  input  1  write strobe; char_data and char_index are sampled on every cycle it is high.
REQ-007 char_index  input  IDX_W  target digit in indexed mode; ignored in scroll mode.
REQ-008 char_data  input  6  character code: 0-9 are digits '0'..'9'; 10-35 are 'A'..'Z'; 36 is blank; 37-62 are reserved; 63 is invalid.
REQ-009 mode  input  1  0 = indexed write, 1 = scroll (shift-in) write.
REQ-010 clear  input  1  blanks all digits.
REQ-011 seg  output  NUM_DIGITS*8  segment patterns, active-high; digit k occupies bits [8k+7:8k], bit order {dp,g,f,e,d,c,b,a}.
REQ-012 char_count  output  IDX_W+1  characters written since the last clear or reset, saturating at NUM_DIGITS.
REQ-013 an  output  NUM_DIGITS  scan anode enables, active-low, one-hot.
REQ-014 cath  output  8  scan cathodes, active-low; equal to the inverse of the pattern of the selected digit.

Function
REQ-015 Code-to-pattern map, fixed by this spec and required exactly: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77; blank=00; reserved=00; invalid(63)=40 (dash).
REQ-016 Patterns for codes B..Z are defined by the team encoding table in the shared package; the table is the single source for those values.
REQ-017 Storage holds decoded 8-bit patterns, not codes; seg is driven directly from storage, so write-to-seg latency is 1 cycle.
REQ-018 Indexed write (mode=0, data_valid=1): digit[char_index] <= pattern(char_data); all other digits are unchanged.
REQ-019 Indexed write with char_index >= NUM_DIGITS: no digit changes and char_count does not change.
REQ-020 Scroll write (mode=1, data_valid=1): digit[k] <= digit[k-1] for k = NUM_DIGITS-1 down to 1; digit[0] <= new pattern; the oldest digit is discarded.
REQ-021 A change of mode preserves the stored contents and takes effect on the next write.
REQ-022 clear=1: all digits <= 00 and char_count <= 0 on the next edge.
REQ-023 clear has priority over data_valid in the same cycle; the write is dropped.
REQ-024 char_count increments by 1 on each accepted write and holds at NUM_DIGITS once reached.
REQ-025 Scan counter runs 0..SCAN_DIV-1 continuously, independent of writes.
REQ-026 At the counter wrap, the digit pointer advances; after NUM_DIGITS-1 it returns to 0.
REQ-027 an and cath are registered from the pointer and the current storage; cath reflects a write to the selected digit one cycle after seg does.
REQ-028 Scan state machine: SCAN_HOLD (counting) transitions to SCAN_ADV (one cycle: pointer increment, counter <= 0), then back to SCAN_HOLD.
REQ-029 Each full digit period is exactly SCAN_DIV cycles, the SCAN_ADV cycle included.

Reset
REQ-030 On reset: all digits <= 00, seg = 0, char_count = 0, scan counter = 0, pointer = 0, scan state = SCAN_HOLD, an = all ones, cath = FF.
REQ-031 reset overrides clear and data_valid.
REQ-032 Scanning restarts from digit 0 on the first cycle after reset deasserts.

Structure
REQ-033 Shared package morse_pkg holds the 6-bit char code constants (CODE_BLANK=36, CODE_INVALID=63), the segment bit-order constants, the code-to-pattern table, and the scan state enum.
REQ-034 Sub-module morse_char_to_seg is purely combinational: 6-bit code in, 8-bit pattern out, implemented from the package table.
REQ-035 The scan counter, pointer, and scan state machine are implemented inline in morse_display_buffer.

Verification (NUM_DIGITS=8, SCAN_DIV=4 unless stated)
REQ-036 Indexed write: mode=0, code 10 at index 3 -> next cycle seg[31:24]=77, other digits 00, char_count=1.
REQ-037 Scroll write: mode=1, codes 1, 2, 3 on consecutive cycles -> digit0=4F, digit1=5B, digit2=06, char_count=3.
REQ-038 Clear priority: write code 8 at index 0, then clear=1 and data_valid=1 (code 5) in the same cycle -> seg=0, char_count=0.
REQ-039 Out-of-range and saturation (NUM_DIGITS=6, IDX_W=3): indexed write to index 7 -> no change; 8 accepted scroll writes -> char_count=6; code 63 at digit0 -> pattern 40.
REQ-040 Scan: digits 0..7 loaded; an steps FE, FD, FB, ... every 4 cycles and wraps to FE after 32 cycles; cath = ~digit[pointer] in every cycle.
REQ-041 Reset mid-operation: reset asserted during scan with pointer=5 -> next cycle seg=0, an=FF, cath=FF; after release an=FE and digit 0 is held for 4 cycles.

Source files
------------

// File: rtl/morse_pkg.sv
// morse_pkg: character codes, segment bit order, code-to-pattern table and scan states
package morse_pkg;
  localparam logic [5:0] CODE_BLANK = 6'd36;
  localparam logic [5:0] CODE_INVALID = 6'd63;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam int SEG_DP = 7;
  localparam logic [7:0] PAT_OFF = 8'h00;
  localparam logic [7:0] PAT_DASH = 8'(1 << SEG_G);
  // Indexed by code 0..36; bit order {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] SEG_TABLE [37] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F,
    8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30, 8'h1E,
    8'h75, 8'h38, 8'h15, 8'h37, 8'h3F, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78,
    8'h3E, 8'h1C, 8'h2A, 8'h49, 8'h6E, 8'h5B, 8'h00
  };
  typedef enum logic {SCAN_HOLD = 1'b0, SCAN_ADV = 1'b1} scan_state_e;
endpackage

// File: rtl/morse_char_to_seg.sv
// morse_char_to_seg: combinational 6-bit character code to 8-bit segment pattern
module morse_char_to_seg
  import morse_pkg::*;
(
  input  logic [5:0] code,
  output logic [7:0] pattern
);
  always_comb pattern = code <= CODE_BLANK ? SEG_TABLE[code] : code == CODE_INVALID ? PAT_DASH : PAT_OFF;
endmodule

// File: rtl/morse_display_buffer.sv
// morse_display_buffer: seven-segment pattern store with indexed/scroll writes and a multiplexed scan
module morse_display_buffer
  import morse_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV = 100000,
  localparam int IDX_W = $clog2(NUM_DIGITS)
) (
  input  logic                    clk_100Mhz,
  input  logic                    reset,
  input  logic                    data_valid,
  input  logic [IDX_W-1:0]        char_index,
  input  logic [5:0]              char_data,
  input  logic                    mode,
  input  logic                    clear,
  output logic [NUM_DIGITS*8-1:0] seg,
  output logic [IDX_W:0]          char_count,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [7:0]              cath
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [IDX_W:0] FULL = (IDX_W+1)'(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST_HOLD = CNT_W'(SCAN_DIV - 2);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(NUM_DIGITS - 1);
  logic [NUM_DIGITS-1:0][7:0] digits_q, digits_d;
  logic [IDX_W:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  scan_state_e state_q, state_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [7:0] cath_q, cath_d;
  logic [7:0] pattern;
  logic wr_ok;
  morse_char_to_seg u_char_to_seg (
    .code(char_data),
    .pattern(pattern)
  );
  // Scroll writes ignore the index; indexed writes beyond the last digit are dropped entirely
  always_comb begin
    wr_ok = data_valid && (mode || {1'b0, char_index} < FULL);
    digits_d = digits_q;
    count_d = count_q;
    if (clear) begin
      digits_d = '0;
      count_d = '0;
    end else if (wr_ok) begin
      if (mode) digits_d = {digits_q[NUM_DIGITS-2:0], pattern};
      else digits_d[char_index] = pattern;
      count_d = count_q == FULL ? count_q : count_q + (IDX_W+1)'(1);
    end
  end
  // The ADV cycle carries counter value SCAN_DIV-1, so each digit lasts exactly SCAN_DIV cycles
  always_comb begin
    cnt_d = state_q == SCAN_ADV ? '0 : cnt_q + CNT_W'(1);
    state_d = state_q == SCAN_HOLD && cnt_q == CNT_LAST_HOLD ? SCAN_ADV : SCAN_HOLD;
    ptr_d = state_q == SCAN_ADV ? (ptr_q == PTR_LAST ? '0 : ptr_q + IDX_W'(1)) : ptr_q;
    an_d = ~(NUM_DIGITS'(1) << ptr_q);
    cath_d = ~digits_q[ptr_q];
  end
  always_ff @(posedge clk_100Mhz) begin
    if (reset) begin
      digits_q <= '0;
      count_q <= '0;
      cnt_q <= '0;
      ptr_q <= '0;
      state_q <= SCAN_HOLD;
      an_q <= '1;
      cath_q <= '1;
    end else begin
      digits_q <= digits_d;
      count_q <= count_d;
      cnt_q <= cnt_d;
      ptr_q <= ptr_d;
      state_q <= state_d;
      an_q <= an_d;
      cath_q <= cath_d;
    end
  end
  assign seg = digits_q;
  assign char_count = count_q;
  assign an = an_q;
  assign cath = cath_q;
endmodule
